// File: rtl/mini_alu_pkg.sv
// Opcode encodings, instruction field layout and decode helper for the mini ALU core.
package mini_alu_pkg;

  localparam int INSTR_W = 28;
  localparam int OP_W    = 4;
  localparam int FIELD_W = 8;
  localparam int OP_LSB  = 24;
  localparam int DST_LSB = 16;
  localparam int S1_LSB  = 8;
  localparam int S0_LSB  = 0;

  typedef enum logic [OP_W-1:0] {
    NOP  = 4'h0,
    ADD  = 4'h1,
    SUB  = 4'h2,
    MUL  = 4'h3,
    STO  = 4'h4,
    BLE  = 4'h5,
    JMP  = 4'h6,
    CALL = 4'h7,
    RET  = 4'h8,
    PUSH = 4'h9,
    POP  = 4'hA,
    LED  = 4'hB,
    PER  = 4'hC
  } opcodeT;

  typedef struct packed {
    opcodeT             op;
    logic [FIELD_W-1:0] dst;
    logic [FIELD_W-1:0] s1;
    logic [FIELD_W-1:0] s0;
  } instrT;

  localparam logic [INSTR_W-1:0] NOP_INSTR = {NOP, 24'h000000};

  // Opcodes 4'hD..4'hF pass through the cast unchanged and fall into the NOP default.
  function automatic instrT decodeInstr(input logic [INSTR_W-1:0] word);
    instrT d;
    d.op  = opcodeT'(word[OP_LSB +: OP_W]);
    d.dst = word[DST_LSB +: FIELD_W];
    d.s1  = word[S1_LSB +: FIELD_W];
    d.s0  = word[S0_LSB +: FIELD_W];
    return d;
  endfunction

endpackage

// File: rtl/mini_alu_core_lifo.sv
// Hardware LIFO for CALL/RET and PUSH/POP; pushes while full are dropped, pops while empty read 0.
module lifo_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] topIdx;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign topIdx  = count[PTR_W-1:0] - PTR_W'(1);
  assign dataOut = empty ? '0 : mem[topIdx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + (PTR_W+1)'(1);
    end else if (pop && !empty) begin
      count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[count[PTR_W-1:0]] <= dataIn;
    end
  end

endmodule

// File: rtl/mini_alu_core.sv
// Two-stage (fetch / execute) mini ALU core with register file, hardware stack, LED and peripheral port.
// Optional MUL instruction is built only when MINI_ALU_MUL_EN is defined.
module mini_alu_core
  import mini_alu_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int IP_W        = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [IP_W-1:0]    oIP,
  input  logic [INSTR_W-1:0] iInstruction,
  output logic [7:0]         oLed,
  output logic [7:0]         oPeriphData,
  output logic               oPeriphWrite,
  input  logic               iPeriphReady,
  output logic               oStackFault
);

  // Stack entries carry both return addresses and data words.
  localparam int STACK_W = (DATA_W > IP_W) ? DATA_W : IP_W;

  logic [INSTR_W-1:0] ir;
  logic [IP_W-1:0]    irAddr;
  logic [DATA_W-1:0]  regFile [256];
  instrT              cur;
  logic [DATA_W-1:0]  rs1;
  logic [DATA_W-1:0]  rs0;
  logic [IP_W-1:0]    retAddr;

  logic               stall;
  logic               regWe;
  logic [DATA_W-1:0]  regWData;
  logic               jumpTaken;
  logic [IP_W-1:0]    jumpTarget;
  logic               ledWe;
  logic               periphStrobe;

  logic               stackPush;
  logic               stackPop;
  logic [STACK_W-1:0] stackDataIn;
  logic [STACK_W-1:0] stackDataOut;
  logic               stackFull;
  logic               stackEmpty;
  logic               stackFault;

  assign cur     = decodeInstr(ir);
  assign rs1     = regFile[cur.s1];
  assign rs0     = regFile[cur.s0];
  assign retAddr = irAddr + IP_W'(1);

  lifo_stack #(
    .WIDTH(STACK_W),
    .DEPTH(STACK_DEPTH)
  ) uStack (
    .clock  (Clock),
    .reset  (Reset),
    .push   (stackPush),
    .pop    (stackPop),
    .dataIn (stackDataIn),
    .dataOut(stackDataOut),
    .full   (stackFull),
    .empty  (stackEmpty)
  );

  always_comb begin
    stall        = 1'b0;
    regWe        = 1'b0;
    regWData     = '0;
    jumpTaken    = 1'b0;
    jumpTarget   = '0;
    ledWe        = 1'b0;
    periphStrobe = 1'b0;
    stackPush    = 1'b0;
    stackPop     = 1'b0;
    stackDataIn  = '0;
    case (cur.op)
      ADD: begin
        regWe    = 1'b1;
        regWData = rs1 + rs0;
      end
      SUB: begin
        regWe    = 1'b1;
        regWData = rs1 - rs0;
      end
`ifdef MINI_ALU_MUL_EN
      MUL: begin
        regWe    = 1'b1;
        regWData = rs1 * rs0;
      end
`endif
      STO: begin
        regWe    = 1'b1;
        regWData = DATA_W'({cur.s1, cur.s0});
      end
      BLE: begin
        jumpTaken  = (rs1 <= rs0);
        jumpTarget = IP_W'(cur.dst);
      end
      JMP: begin
        jumpTaken  = 1'b1;
        jumpTarget = IP_W'(cur.dst);
      end
      CALL: begin
        stackPush   = 1'b1;
        stackDataIn = STACK_W'(retAddr);
        jumpTaken   = 1'b1;
        jumpTarget  = IP_W'(cur.dst);
      end
      RET: begin
        stackPop   = 1'b1;
        jumpTaken  = 1'b1;
        jumpTarget = stackDataOut[IP_W-1:0];
      end
      PUSH: begin
        stackPush   = 1'b1;
        stackDataIn = STACK_W'(rs0);
      end
      POP: begin
        stackPop = 1'b1;
        regWe    = 1'b1;
        regWData = stackDataOut[DATA_W-1:0];
      end
      LED: ledWe = 1'b1;
      PER: begin
        periphStrobe = iPeriphReady;
        stall        = !iPeriphReady;
      end
      default: ;
    endcase
  end

  assign stackFault   = (stackPush && stackFull) || (stackPop && stackEmpty);
  assign oPeriphWrite = periphStrobe;
  assign oPeriphData  = periphStrobe ? rs1[7:0] : 8'h00;

  // A taken jump discards the word fetched behind it by loading a NOP into IR.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oIP         <= '0;
      ir          <= NOP_INSTR;
      irAddr      <= '0;
      oLed        <= 8'h00;
      oStackFault <= 1'b0;
    end else if (!stall) begin
      if (jumpTaken) begin
        oIP <= jumpTarget;
        ir  <= NOP_INSTR;
      end else begin
        oIP    <= oIP + IP_W'(1);
        ir     <= iInstruction;
        irAddr <= oIP;
      end
      if (ledWe) begin
        oLed <= rs1[7:0];
      end
      if (stackFault) begin
        oStackFault <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (regWe && !stall) begin
      regFile[cur.dst] <= regWData;
    end
  end

endmodule

// File: tb/tb_mini_alu_core.sv
// Directed self-checking bench for mini_alu_core: ALU vector table, branch table, call/return, stall and stack sequences.
module tb_mini_alu_core;
  import mini_alu_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] oIP;
  logic [27:0] iInstruction;
  logic [7:0]  oLed;
  logic [7:0]  oPeriphData;
  logic        oPeriphWrite;
  logic        iPeriphReady;
  logic        oStackFault;

  logic [27:0] rom [256];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    string       name;
    logic [27:0] instr;
    bit          check;
    logic [7:0]  regIdx;
    logic [15:0] expVal;
  } aluVecT;

  typedef struct {
    logic [15:0] r1;
    logic [15:0] r2;
    bit          taken;
  } bleVecT;

  aluVecT aluVecs [15];
  bleVecT bleVecs [4];
  int     aluCount = 0;

`ifdef MINI_ALU_MUL_EN
  localparam logic [15:0] MUL_EXP = 16'h5F90;
`else
  localparam logic [15:0] MUL_EXP = 16'h1234;
`endif

  mini_alu_core #(
    .DATA_W     (16),
    .IP_W       (16),
    .STACK_DEPTH(8)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .oIP         (oIP),
    .iInstruction(iInstruction),
    .oLed        (oLed),
    .oPeriphData (oPeriphData),
    .oPeriphWrite(oPeriphWrite),
    .iPeriphReady(iPeriphReady),
    .oStackFault (oStackFault)
  );

  always #5 Clock = ~Clock;

  assign iInstruction = rom[oIP[7:0]];

  function automatic logic [27:0] mk(input logic [3:0] op, input logic [7:0] dst,
                                     input logic [7:0] s1, input logic [7:0] s0);
    return {op, dst, s1, s0};
  endfunction

  task automatic addAlu(input string name, input logic [27:0] instr, input bit check,
                        input logic [7:0] regIdx, input logic [15:0] expVal);
    aluVecs[aluCount] = '{name, instr, check, regIdx, expVal};
    aluCount++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = NOP_INSTR;
  endtask

  task automatic resetCore(input logic ready);
    iPeriphReady = ready;
    Reset = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge Clock);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    iPeriphReady = 1'b0;
    clearRom();

    // Asynchronous reset takes effect before any clock edge.
    #2 Reset = 1'b1;
    #1;
    checkOutput("rst_ip", 32'(oIP), 32'h0);
    checkOutput("rst_led", 32'(oLed), 32'h0);
    checkOutput("rst_pdata", 32'(oPeriphData), 32'h0);
    checkOutput("rst_pwrite", 32'(oPeriphWrite), 32'h0);
    checkOutput("rst_fault", 32'(oStackFault), 32'h0);

    // ALU vector table: program placed at address 0, all results checked at the end.
    addAlu("sto_r1",   mk(STO, 8'd1, 8'h00, 8'h05), 1'b1, 8'd1, 16'h0005);
    addAlu("sto_r2",   mk(STO, 8'd2, 8'h00, 8'h03), 1'b1, 8'd2, 16'h0003);
    addAlu("sub_r3",   mk(SUB, 8'd3, 8'd2, 8'd1),   1'b1, 8'd3, 16'hFFFE);
    addAlu("add_r4",   mk(ADD, 8'd4, 8'd1, 8'd2),   1'b1, 8'd4, 16'h0008);
    addAlu("sto_ffff", mk(STO, 8'd5, 8'hFF, 8'hFF), 1'b1, 8'd5, 16'hFFFF);
    addAlu("add_wrap", mk(ADD, 8'd6, 8'd5, 8'd2),   1'b1, 8'd6, 16'h0002);
    addAlu("sto_300",  mk(STO, 8'd7, 8'h01, 8'h2C), 1'b1, 8'd7, 16'h012C);
    addAlu("sto_r8",   mk(STO, 8'd8, 8'h12, 8'h34), 1'b0, 8'd8, 16'h0000);
    addAlu("mul",      mk(MUL, 8'd8, 8'd7, 8'd7),   1'b1, 8'd8, MUL_EXP);
    addAlu("sto_r9",   mk(STO, 8'd9, 8'hAB, 8'hCD), 1'b0, 8'd9, 16'h0000);
    addAlu("undef_op", mk(4'hD, 8'd9, 8'd1, 8'd2),  1'b1, 8'd9, 16'hABCD);
    addAlu("sub_zero", mk(SUB, 8'd10, 8'd1, 8'd1),  1'b1, 8'd10, 16'h0000);
    addAlu("sto_hi",   mk(STO, 8'd11, 8'hFF, 8'h00), 1'b1, 8'd11, 16'hFF00);
    addAlu("sub_neg",  mk(SUB, 8'd12, 8'd1, 8'd4),  1'b1, 8'd12, 16'hFFFD);
    addAlu("nop_r1",   mk(NOP, 8'd1, 8'hFF, 8'hFF), 1'b1, 8'd1, 16'h0005);
    clearRom();
    for (int i = 0; i < aluCount; i++) rom[i] = aluVecs[i].instr;
    rom[aluCount] = mk(LED, 8'd0, 8'd3, 8'd0);
    resetCore(1'b0);
    applyStimulus(20);
    for (int i = 0; i < aluCount; i++) begin
      if (aluVecs[i].check) begin
        checkOutput(aluVecs[i].name, 32'(dut.regFile[aluVecs[i].regIdx]), 32'(aluVecs[i].expVal));
      end
    end
    checkOutput("led_r3", 32'(oLed), 32'h00FE);

    // Branch table: taken jumps go to 0x20 and squash the slot at address 3.
    bleVecs[0] = '{16'h0003, 16'h0003, 1'b1};
    bleVecs[1] = '{16'h0004, 16'h0003, 1'b0};
    bleVecs[2] = '{16'h8004, 16'h0003, 1'b0};
    bleVecs[3] = '{16'h0005, 16'h8003, 1'b1};
    for (int i = 0; i < 4; i++) begin
      clearRom();
      rom[0]    = mk(STO, 8'd1, bleVecs[i].r1[15:8], bleVecs[i].r1[7:0]);
      rom[1]    = mk(STO, 8'd2, bleVecs[i].r2[15:8], bleVecs[i].r2[7:0]);
      rom[2]    = mk(BLE, 8'h20, 8'd1, 8'd2);
      rom[3]    = mk(LED, 8'd0, 8'd2, 8'd0);
      rom[8'h20] = mk(LED, 8'd0, 8'd1, 8'd0);
      resetCore(1'b0);
      applyStimulus(4);
      checkOutput($sformatf("ble%0d_ip", i), 32'(oIP), bleVecs[i].taken ? 32'h20 : 32'h4);
      applyStimulus(1);
      checkOutput($sformatf("ble%0d_slot", i), 32'(oLed),
                  bleVecs[i].taken ? 32'h0 : 32'(bleVecs[i].r2[7:0]));
      applyStimulus(1);
      checkOutput($sformatf("ble%0d_led", i), 32'(oLed),
                  bleVecs[i].taken ? 32'(bleVecs[i].r1[7:0]) : 32'(bleVecs[i].r2[7:0]));
    end

    // CALL at 0x10 to 0x40, RET returns to 0x11.
    clearRom();
    rom[0]     = mk(JMP, 8'h10, 8'd0, 8'd0);
    rom[8'h10] = mk(CALL, 8'h40, 8'd0, 8'd0);
    rom[8'h40] = mk(RET, 8'd0, 8'd0, 8'd0);
    resetCore(1'b0);
    applyStimulus(4);
    checkOutput("call_ip", 32'(oIP), 32'h40);
    applyStimulus(2);
    checkOutput("ret_ip", 32'(oIP), 32'h11);
    checkOutput("call_fault", 32'(oStackFault), 32'h0);

    // RET on an empty stack jumps to 0 and raises the fault.
    clearRom();
    rom[0]     = mk(JMP, 8'h30, 8'd0, 8'd0);
    rom[8'h30] = mk(RET, 8'd0, 8'd0, 8'd0);
    resetCore(1'b0);
    applyStimulus(3);
    checkOutput("ret_empty_pre", 32'(oStackFault), 32'h0);
    applyStimulus(1);
    checkOutput("ret_empty_ip", 32'(oIP), 32'h0);
    checkOutput("ret_empty_fault", 32'(oStackFault), 32'h1);

    // PER stalls for five cycles, then strobes once when ready rises.
    clearRom();
    rom[0] = mk(STO, 8'd5, 8'h00, 8'hA5);
    rom[1] = mk(PER, 8'd0, 8'd5, 8'd0);
    rom[2] = mk(STO, 8'd6, 8'h00, 8'h01);
    resetCore(1'b0);
    applyStimulus(2);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("stall%0d_ip", k), 32'(oIP), 32'h2);
      checkOutput($sformatf("stall%0d_wr", k), 32'(oPeriphWrite), 32'h0);
    end
    iPeriphReady = 1'b1;
    #1;
    checkOutput("per_wr", 32'(oPeriphWrite), 32'h1);
    checkOutput("per_data", 32'(oPeriphData), 32'hA5);
    applyStimulus(1);
    checkOutput("per_wr_done", 32'(oPeriphWrite), 32'h0);
    checkOutput("per_ip_next", 32'(oIP), 32'h3);

    // Reset during a stall aborts the pending PER.
    resetCore(1'b0);
    applyStimulus(3);
    Reset = 1'b1;
    #1;
    checkOutput("abort_ip", 32'(oIP), 32'h0);
    iPeriphReady = 1'b1;
    #1;
    checkOutput("abort_wr", 32'(oPeriphWrite), 32'h0);
    applyStimulus(1);
    Reset = 1'b0;

    // Nine pushes overflow an 8-deep stack; pops come back LIFO, then an extra pop reads 0.
    clearRom();
    for (int i = 0; i < 9; i++) rom[i] = mk(STO, 8'(i + 1), 8'h01, 8'(i + 1));
    rom[9] = mk(STO, 8'd29, 8'hBE, 8'hEF);
    for (int j = 0; j < 9; j++) rom[10 + j] = mk(PUSH, 8'd0, 8'd0, 8'(j + 1));
    for (int k = 0; k < 8; k++) rom[19 + k] = mk(POP, 8'(21 + k), 8'd0, 8'd0);
    rom[27] = mk(POP, 8'd29, 8'd0, 8'd0);
    resetCore(1'b0);
    applyStimulus(19);
    checkOutput("push8_fault", 32'(oStackFault), 32'h0);
    applyStimulus(1);
    checkOutput("push9_fault", 32'(oStackFault), 32'h1);
    applyStimulus(10);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("pop%0d", k), 32'(dut.regFile[21 + k]), 32'h0100 + 32'(8 - k));
    end
    checkOutput("pop_empty", 32'(dut.regFile[29]), 32'h0);
    checkOutput("fault_sticky", 32'(oStackFault), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
